// File: rtl/fir_2d_array_ctrl.sv
// Frame sequencer for the 64-lane 2D FIR array: coefficient load, data stream,
// then drain of valid_core returns, with busy/done/timeout status.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | waiting for start; lengths latched on accepted start
// S_LOAD   | src_ready=1, each accepted word pulses tc_set
// S_STREAM | src_ready=1, each accepted word pulses valid_dmac
// S_DRAIN  | waiting for out_cnt to reach frame_beats or the idle timer to expire
// S_DONE   | frame finished; done pulses on the following cycle
module fir_2d_array_ctrl #(
    parameter int CNT_W         = 16,
    parameter int COEF_W        = 4,
    parameter int DRAIN_TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  frame_beats,
    input  logic [COEF_W-1:0] coef_len,
    input  logic              src_valid,
    output logic              src_ready,
    output logic              tc_set,
    output logic              valid_dmac,
    input  logic              valid_core,
    output logic              busy,
    output logic              done,
    output logic              err_timeout,
    output logic [CNT_W-1:0]  out_cnt
);

    localparam int TMR_W = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_TOP = TMR_W'(DRAIN_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [CNT_W-1:0]    beats_q;
    logic [CNT_W-1:0]    beats_d;
    logic [COEF_W-1:0]   coef_q;
    logic [COEF_W-1:0]   coef_d;
    logic [COEF_W-1:0]   coef_cnt_q;
    logic [COEF_W-1:0]   coef_cnt_d;
    logic [CNT_W-1:0]    in_cnt_q;
    logic [CNT_W-1:0]    in_cnt_d;
    logic [CNT_W-1:0]    out_cnt_q;
    logic [CNT_W-1:0]    out_cnt_d;
    logic [TMR_W-1:0]    tmr_q;
    logic [TMR_W-1:0]    tmr_d;
    logic                err_q;
    logic                err_d;
    logic                busy_q;
    logic                busy_d;
    logic                done_q;
    logic                done_d;
    logic                accept;

    always_comb begin
        src_ready  = (state_q == S_LOAD) || (state_q == S_STREAM);
        tc_set     = (state_q == S_LOAD) && src_valid;
        valid_dmac = (state_q == S_STREAM) && src_valid;
        accept     = src_valid && src_ready;
    end

    always_comb begin
        state_d    = state_q;
        beats_d    = beats_q;
        coef_d     = coef_q;
        coef_cnt_d = coef_cnt_q;
        in_cnt_d   = in_cnt_q;
        out_cnt_d  = out_cnt_q;
        tmr_d      = tmr_q;
        err_d      = err_q;

        // Returns are counted while streaming too; extras past frame_beats are dropped.
        if (((state_q == S_STREAM) || (state_q == S_DRAIN)) && valid_core &&
            (out_cnt_q != beats_q)) begin
            out_cnt_d = out_cnt_q + CNT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    beats_d    = frame_beats;
                    coef_d     = coef_len;
                    coef_cnt_d = '0;
                    in_cnt_d   = '0;
                    out_cnt_d  = '0;
                    tmr_d      = TMR_TOP;
                    err_d      = 1'b0;
                    if (coef_len != '0) begin
                        state_d = S_LOAD;
                    end else if (frame_beats != '0) begin
                        state_d = S_STREAM;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_LOAD: begin
                if (accept) begin
                    coef_cnt_d = coef_cnt_q + COEF_W'(1);
                    if (coef_cnt_d == coef_q) begin
                        state_d = (beats_q != '0) ? S_STREAM : S_DONE;
                    end
                end
            end
            S_STREAM: begin
                if (accept) begin
                    in_cnt_d = in_cnt_q + CNT_W'(1);
                    if (in_cnt_d == beats_q) begin
                        state_d = S_DRAIN;
                        tmr_d   = TMR_TOP;
                    end
                end
            end
            S_DRAIN: begin
                // Idle timer counts down from the timeout and reloads on every return.
                if (out_cnt_d == beats_q) begin
                    state_d = S_DONE;
                end else if (valid_core) begin
                    tmr_d = TMR_TOP;
                end else if (tmr_q == TMR_W'(1)) begin
                    tmr_d   = '0;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // busy stays up through the done pulse that follows S_DONE.
        busy_d = (state_d != S_IDLE) || (state_q == S_DONE);
        done_d = (state_q == S_DONE);

        if (abort) begin
            state_d    = S_IDLE;
            beats_d    = beats_q;
            coef_d     = coef_q;
            coef_cnt_d = coef_cnt_q;
            in_cnt_d   = in_cnt_q;
            out_cnt_d  = out_cnt_q;
            tmr_d      = tmr_q;
            err_d      = err_q;
            busy_d     = 1'b0;
            done_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            beats_q    <= '0;
            coef_q     <= '0;
            coef_cnt_q <= '0;
            in_cnt_q   <= '0;
            out_cnt_q  <= '0;
            tmr_q      <= '0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            beats_q    <= beats_d;
            coef_q     <= coef_d;
            coef_cnt_q <= coef_cnt_d;
            in_cnt_q   <= in_cnt_d;
            out_cnt_q  <= out_cnt_d;
            tmr_q      <= tmr_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign err_timeout = err_q;
    assign out_cnt     = out_cnt_q;

endmodule
